// File: rtl/hex_display_pkg.sv
// Shared types and constants for the multiplexed hex display driver.
package hex_display_pkg;

  // Per-slot phase: BLANK keeps every anode off to hide ghosting while the
  // segment lines settle; ON lights the selected digit.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_e;

  // Active-low segment codes {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  // All segments off.
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/hex_scan_driver_if.sv
// Signal bundle between a display client and the hex scan driver.
interface hex_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [7:0]              AN;
  logic [6:0]              SEG;
  logic                    DP;
  logic                    frame_start;

  // Client side: supplies digits, observes the panel drive.
  modport master (
    output value, dp, digit_en,
    input  AN, SEG, DP, frame_start
  );

  // Driver side.
  modport slave (
    input  value, dp, digit_en,
    output AN, SEG, DP, frame_start
  );
endinterface

// File: rtl/seven_segment_decoder.sv
// Combinational hex nibble to active-low seven-segment code.
module seven_segment_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup.
  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed driver for up to eight common-anode hex digits.
// Inputs are snapshotted once per frame so a frame never mixes old and new
// data; every panel output is registered.
module hex_scan_driver
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_BLANK     = 1
) (
  input  logic                    CLK100MHZ,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [7:0]              AN,
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic                    frame_start
);

  localparam int PW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SLOT_CYCLES - 1);
  localparam logic [2:0]    SLOT_LAST  = 3'(NUM_DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    slot_q, slot_d;
  scan_state_e   state_q, state_d;
  logic          first_q;
  logic          frame_end, capture, in_blank_d;

  logic [31:0]   val_q;
  logic [7:0]    dp_q, en_q;
  logic [7:0]    lz_sup;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;
  logic          active;

  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_out_q;
  logic          fs_q;

  assign frame_end = (slot_q == SLOT_LAST) && (presc_q == PRESC_LAST);
  // The first edge after reset takes a fresh snapshot and holds the counter,
  // so the first frame starts at slot 0 with valid data like every other one.
  assign capture   = first_q || frame_end;

  // Next prescaler / slot index, frozen on the post-reset snapshot edge.
  always_comb begin
    presc_d = presc_q;
    slot_d  = slot_q;
    if (!first_q) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        slot_d  = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign in_blank_d = 1'b0;
    end else begin : g_blank
      assign in_blank_d = (presc_d < PW'(BLANK_CYCLES));
    end
  endgenerate

  // Counter state and the post-reset marker.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      slot_q  <= '0;
      first_q <= 1'b1;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
      first_q <= 1'b0;
    end
  end

  // Slot phase register.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) state_q <= ST_BLANK;
    else     state_q <= state_d;
  end

  // Phase follows the prescaler position the counter is about to enter.
  always_comb begin
    state_d = ST_ON;
    if (in_blank_d) state_d = ST_BLANK;
  end

  // Frame snapshot of the client inputs, zero-padded to eight digits.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      val_q <= '0;
      dp_q  <= '0;
      en_q  <= '0;
    end else if (capture) begin
      val_q <= 32'(value);
      dp_q  <= 8'(dp);
      en_q  <= 8'(digit_en);
    end
  end

  // Leading-zero suppression: digit i>0 goes dark when it and every digit
  // above it are zero. Digit 0 always shows so a zero value reads "0".
  generate
    for (genvar i = 0; i < 8; i++) begin : g_lz
      if (LZ_BLANK != 0 && i > 0 && i < NUM_DIGITS) begin : g_on
        assign lz_sup[i] = ~|val_q[31:4*i];
      end else begin : g_off
        assign lz_sup[i] = 1'b0;
      end
    end
  endgenerate

  assign nibble = val_q[{slot_q, 2'b00} +: 4];

  seven_segment_decoder u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // During the post-reset hold state_q is still BLANK, so nothing lights.
  assign active = (state_q == ST_ON) && en_q[slot_q] && !lz_sup[slot_q];

  // Registered panel drive; unused anodes stay high because slot < NUM_DIGITS.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      an_q     <= 8'hFF;
      seg_q    <= SEG_OFF;
      dp_out_q <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      an_q     <= active ? ~(8'd1 << slot_q) : 8'hFF;
      seg_q    <= active ? seg_dec : SEG_OFF;
      dp_out_q <= ~(active && dp_q[slot_q]);
      fs_q     <= capture;
    end
  end

  assign AN          = an_q;
  assign SEG         = seg_q;
  assign DP          = dp_out_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench: a 4-digit driver (8-cycle slots, 2 blank cycles) and a
// 1-digit driver with no blanking share clock and reset.
module tb_hex_scan_driver;

  logic clk;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  hex_scan_if #(.NUM_DIGITS(4)) b4 ();
  hex_scan_if #(.NUM_DIGITS(1)) b1 ();

  hex_scan_driver #(
    .NUM_DIGITS(4), .SLOT_CYCLES(8), .BLANK_CYCLES(2), .LZ_BLANK(1)
  ) dut4 (
    .CLK100MHZ   (clk),
    .RST         (rst),
    .value       (b4.value),
    .dp          (b4.dp),
    .digit_en    (b4.digit_en),
    .AN          (b4.AN),
    .SEG         (b4.SEG),
    .DP          (b4.DP),
    .frame_start (b4.frame_start)
  );

  hex_scan_driver #(
    .NUM_DIGITS(1), .SLOT_CYCLES(8), .BLANK_CYCLES(0), .LZ_BLANK(1)
  ) dut1 (
    .CLK100MHZ   (clk),
    .RST         (rst),
    .value       (b1.value),
    .dp          (b1.dp),
    .digit_en    (b1.digit_en),
    .AN          (b1.AN),
    .SEG         (b1.SEG),
    .DP          (b1.DP),
    .frame_start (b1.frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a frame_start pulse, sampled on falling edges.
  task automatic wait_fs(input int sel);
    bit got = 0;
    int n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = (sel == 4) ? b4.frame_start : b1.frame_start;
      n++;
    end
    chk($sformatf("fs_wait%0d", sel), {31'd0, got}, 32'd1);
  endtask

  // Called on the frame_start cycle; checks the 31 following cycles.
  // Optionally changes value mid-frame at offset chg_k.
  task automatic check_frame(input string name,
                             input logic [3:0][7:0] an,
                             input logic [3:0][6:0] seg,
                             input logic [3:0]      dpx,
                             input int              chg_k,
                             input logic [15:0]     chg_val);
    int s, p;
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      if (k == chg_k) b4.value = chg_val;
      s = (k - 1) / 8;
      p = (k - 1) % 8;
      if (p < 2) begin
        chk($sformatf("%s an s%0d p%0d", name, s, p), {24'd0, b4.AN}, 32'hFF);
        chk($sformatf("%s seg s%0d p%0d", name, s, p), {25'd0, b4.SEG}, 32'h7F);
        chk($sformatf("%s dp s%0d p%0d", name, s, p), {31'd0, b4.DP}, 32'd1);
      end else begin
        chk($sformatf("%s an s%0d p%0d", name, s, p), {24'd0, b4.AN}, {24'd0, an[s]});
        chk($sformatf("%s seg s%0d p%0d", name, s, p), {25'd0, b4.SEG}, {25'd0, seg[s]});
        chk($sformatf("%s dp s%0d p%0d", name, s, p), {31'd0, b4.DP}, {31'd0, dpx[s]});
      end
      chk($sformatf("%s fs k%0d", name, k), {31'd0, b4.frame_start}, 32'd0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    b4.value    = 16'h12AF;
    b4.digit_en = 4'hF;
    b4.dp       = 4'h0;
    b1.value    = 4'h5;
    b1.digit_en = 1'b1;
    b1.dp       = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst an4",  {24'd0, b4.AN}, 32'hFF);
    chk("rst seg4", {25'd0, b4.SEG}, 32'h7F);
    chk("rst dp4",  {31'd0, b4.DP}, 32'd1);
    chk("rst fs4",  {31'd0, b4.frame_start}, 32'd0);
    chk("rst an1",  {24'd0, b1.AN}, 32'hFF);
    chk("rst fs1",  {31'd0, b1.frame_start}, 32'd0);

    // Basic scan of 12AF: slots show F, A, 2, 1.
    rst = 1'b0;
    @(negedge clk);
    chk("fs after release", {31'd0, b4.frame_start}, 32'd1);
    check_frame("basic", {8'hF7, 8'hFB, 8'hFD, 8'hFE},
                {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, -1, 16'h0);

    // Leading-zero suppression.
    b4.value = 16'h0030;
    wait_fs(4);
    check_frame("lz30", {8'hFF, 8'hFF, 8'hFD, 8'hFE},
                {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'hF, -1, 16'h0);
    b4.value = 16'h0000;
    wait_fs(4);
    check_frame("lz0", {8'hFF, 8'hFF, 8'hFF, 8'hFE},
                {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, -1, 16'h0);

    // Mid-frame change is held off until the next snapshot.
    b4.value = 16'h1111;
    wait_fs(4);
    check_frame("hold1", {8'hF7, 8'hFB, 8'hFD, 8'hFE},
                {7'h79, 7'h79, 7'h79, 7'h79}, 4'hF, 20, 16'h2222);
    wait_fs(4);
    check_frame("new2", {8'hF7, 8'hFB, 8'hFD, 8'hFE},
                {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, -1, 16'h0);

    // Digit enables and decimal point.
    b4.value    = 16'h12AF;
    b4.digit_en = 4'b0101;
    b4.dp       = 4'b0100;
    wait_fs(4);
    check_frame("en_dp", {8'hFF, 8'hFB, 8'hFF, 8'hFE},
                {7'h7F, 7'h24, 7'h7F, 7'h0E}, 4'b1011, -1, 16'h0);

    // Single digit, no blanking: always lit, frame every 8 cycles.
    wait_fs(1);
    for (int k = 0; k < 24; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("d1 an k%0d", k), {24'd0, b1.AN}, 32'hFE);
      chk($sformatf("d1 seg k%0d", k), {25'd0, b1.SEG}, 32'h12);
      chk($sformatf("d1 fs k%0d", k), {31'd0, b1.frame_start},
          (k % 8 == 0) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of slot 2 ON.
    b4.digit_en = 4'hF;
    b4.dp       = 4'h0;
    wait_fs(4);
    repeat (20) @(negedge clk);
    chk("pre-rst an", {24'd0, b4.AN}, 32'hFB);
    #1 rst = 1'b1;
    #1;
    chk("async an",  {24'd0, b4.AN}, 32'hFF);
    chk("async seg", {25'd0, b4.SEG}, 32'h7F);
    chk("async dp",  {31'd0, b4.DP}, 32'd1);
    chk("async fs",  {31'd0, b4.frame_start}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("fs after midrst", {31'd0, b4.frame_start}, 32'd1);
    check_frame("restart", {8'hF7, 8'hFB, 8'hFD, 8'hFE},
                {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, -1, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
